// File: rtl/bus_slave_if_pkg.sv
// bus_slave_if_pkg: shared bus encodings, widths and slave FSM states
package bus_slave_if_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;
  localparam int WAIT_W = 4;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic [1:0] {
    BUS_SLAVE_IDLE = 2'd0,
    BUS_SLAVE_WAIT = 2'd1,
    BUS_SLAVE_ACK  = 2'd2
  } state_t;
endpackage

// File: rtl/bus_slave_if.sv
// bus_slave_if: bus responder with wait states and a 32-bit register bank
module bus_slave_if
  import bus_slave_if_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_cs_,
  input  logic                         s_as_,
  input  logic                         s_rw,
  input  logic [WORD_ADDR_W-1:0]       s_addr,
  input  logic [WORD_DATA_W-1:0]       s_wr_data,
  output logic [WORD_DATA_W-1:0]       s_rd_data,
  output logic                         s_rdy_,
  output logic [NUM_REGS*32-1:0]       regs_o
);
  state_t state, next;
  logic [WAIT_W-1:0] cnt;
  logic [IDX_W-1:0] idx, use_idx;
  logic rw, use_rw, accept, enter_ack;
  logic [WORD_DATA_W-1:0] wd, use_wd;
  logic [31:0] regs [NUM_REGS];
  logic addr_unused;
  assign addr_unused = ^s_addr[WORD_ADDR_W-1:IDX_W];
  // state register
  always_ff @(posedge clk)
    state <= reset ? BUS_SLAVE_IDLE : next;
  // next-state: accept in IDLE, count down in WAIT, ACK lasts one cycle
  always_comb begin
    next = BUS_SLAVE_IDLE;
    if (state == BUS_SLAVE_IDLE)
      next = accept ? (WAIT_CYCLES == 0 ? BUS_SLAVE_ACK : BUS_SLAVE_WAIT) : BUS_SLAVE_IDLE;
    else if (state == BUS_SLAVE_WAIT)
      next = cnt == '0 ? BUS_SLAVE_ACK : BUS_SLAVE_WAIT;
  end
  // request qualification; with zero wait states the live inputs feed the ACK edge
  always_comb begin
    accept = state == BUS_SLAVE_IDLE && s_cs_ == ENABLE_ && s_as_ == ENABLE_;
    enter_ack = next == BUS_SLAVE_ACK;
    use_idx = state == BUS_SLAVE_IDLE ? s_addr[IDX_W-1:0] : idx;
    use_rw = state == BUS_SLAVE_IDLE ? s_rw : rw;
    use_wd = state == BUS_SLAVE_IDLE ? s_wr_data : wd;
  end
  // request latches, wait counter, register bank and registered response
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      rw <= 1'b0;
      wd <= '0;
      s_rdy_ <= DISABLE_;
      s_rd_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (accept) begin
        idx <= s_addr[IDX_W-1:0];
        rw <= s_rw;
        wd <= s_wr_data;
      end
      cnt <= accept ? WAIT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0)
           : (state == BUS_SLAVE_WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
      s_rdy_ <= enter_ack ? ENABLE_ : DISABLE_;
      s_rd_data <= (enter_ack && use_rw == READ) ? regs[use_idx] : '0;
      if (enter_ack && use_rw == WRITE) regs[use_idx] <= use_wd;
    end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[32*g +: 32] = regs[g];
  end
endmodule

// File: tb/tb_bus_slave_if.sv
// tb_bus_slave_if: directed checks of bus_slave_if at 0, 1 and 15 wait states
module tb_bus_slave_if;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs0_ = 1'b1, cs1_ = 1'b1, cs15_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd0, rd1, rd15;
  logic rdy0, rdy1, rdy15;
  logic [127:0] regs0, regs1, regs15;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bus_slave_if #(.NUM_REGS(4), .IDX_W(2), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .s_cs_(cs0_), .s_as_(as_), .s_rw(rw), .s_addr(addr),
    .s_wr_data(wd), .s_rd_data(rd0), .s_rdy_(rdy0), .regs_o(regs0));
  bus_slave_if #(.NUM_REGS(4), .IDX_W(2), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .s_cs_(cs1_), .s_as_(as_), .s_rw(rw), .s_addr(addr),
    .s_wr_data(wd), .s_rd_data(rd1), .s_rdy_(rdy1), .regs_o(regs1));
  bus_slave_if #(.NUM_REGS(4), .IDX_W(2), .WAIT_CYCLES(15)) u15 (
    .clk(clk), .reset(reset), .s_cs_(cs15_), .s_as_(as_), .s_rw(rw), .s_addr(addr),
    .s_wr_data(wd), .s_rd_data(rd15), .s_rdy_(rdy15), .regs_o(regs15));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int w);
    return w == 0 ? rdy0 : w == 1 ? rdy1 : rdy15;
  endfunction

  function automatic logic [31:0] rd_of(input int w);
    return w == 0 ? rd0 : w == 1 ? rd1 : rd15;
  endfunction

  task automatic start(input int w, input logic r, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    cs0_ = w != 0;
    cs1_ = w != 1;
    cs15_ = w != 15;
    as_ = 1'b0;
    rw = r;
    addr = a;
    wd = d;
    @(posedge clk);
  endtask

  task automatic expect_rdy(input int w, input int n, input logic [31:0] d, input string tag);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      chk($sformatf("%s rdy k=%0d", tag, k), {127'b0, rdy_of(w)}, {127'b0, k != n});
      chk($sformatf("%s rd k=%0d", tag, k), {96'b0, rd_of(w)}, k == n ? {96'b0, d} : 128'b0);
      if (k == 1) begin
        cs0_ = 1'b1;
        cs1_ = 1'b1;
        cs15_ = 1'b1;
        as_ = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    chk("reset rd", {96'b0, rd1}, 128'b0);
    chk("reset regs1", regs1, 128'b0);
    chk("reset regs15", regs15, 128'b0);
    cs1_ = 1'b0;
    as_ = 1'b1;
    rw = 1'b0;
    wd = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("cs only rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    end
    cs1_ = 1'b1;
    as_ = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("as only rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    end
    chk("no accept regs", regs1, 128'b0);
    as_ = 1'b1;

    start(1, 1'b0, 30'd2, 32'hDEAD_BEEF);
    expect_rdy(1, 2, 32'h0, "w1 write");
    chk("w1 reg2", regs1, {32'h0, 32'hDEAD_BEEF, 64'h0});
    start(1, 1'b1, 30'd2, 32'h0);
    expect_rdy(1, 2, 32'hDEAD_BEEF, "w1 read");

    start(0, 1'b0, 30'd3, 32'h0BAD_F00D);
    expect_rdy(0, 1, 32'h0, "w0 write");
    chk("w0 reg3", regs0, {32'h0BAD_F00D, 96'h0});
    start(0, 1'b1, 30'd3, 32'h0);
    expect_rdy(0, 1, 32'h0BAD_F00D, "w0 read");

    start(15, 1'b0, 30'd1, 32'hCAFE_F00D);
    expect_rdy(15, 16, 32'h0, "w15 write");
    chk("w15 reg1", regs15, {64'h0, 32'hCAFE_F00D, 32'h0});
    start(15, 1'b1, 30'd1, 32'h0);
    expect_rdy(15, 16, 32'hCAFE_F00D, "w15 read");

    start(1, 1'b0, 30'd1, 32'h1111_1111);
    @(negedge clk);
    chk("busy wait rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    addr = 30'd3;
    wd = 32'h2222_2222;
    rw = 1'b1;
    @(negedge clk);
    chk("busy ack rdy", {127'b0, rdy1}, {127'b0, 1'b0});
    chk("busy ack rd", {96'b0, rd1}, 128'b0);
    cs1_ = 1'b1;
    as_ = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("busy after rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    end
    chk("busy regs", regs1, {32'h0, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0});

    start(1, 1'b0, 30'h0000_0105, 32'hA5A5_A5A5);
    expect_rdy(1, 2, 32'h0, "alias write");
    chk("alias regs", regs1, {32'h0, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h0});

    start(1, 1'b0, 30'd0, 32'h1234_5678);
    @(negedge clk);
    cs1_ = 1'b1;
    as_ = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    chk("midreset regs", regs1, 128'b0);
    repeat (3) begin
      @(negedge clk);
      chk("midreset quiet rdy", {127'b0, rdy1}, {127'b0, 1'b1});
    end
    start(1, 1'b1, 30'd0, 32'h0);
    expect_rdy(1, 2, 32'h0, "post reset read");
    chk("post reset regs", regs1, 128'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bus_slave_if.md
Name: bus_slave_if

Overview:
- Generic bus responder: the slave-side end of the shared bus whose chip selects come from the address decoder.
- Accepts a request when its active-low chip select and address strobe are both asserted.
- Performs a read or write on an internal bank of 32-bit registers after a programmable number of wait states.
- Returns an active-low ready pulse with read data toward the slave multiplexer; register contents are also exported flat for peripheral control.

Parameters:
- NUM_REGS, 4, number of 32-bit registers; power of two, 2..16.
- IDX_W, 2, log2(NUM_REGS); selects the register from the low word-address bits.
- WAIT_CYCLES, 1, wait states between accept and ready; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_cs_  in  1  chip select from address decoder, active low.
- s_as_  in  1  address strobe, active low.
- s_rw  in  1  1 = read, 0 = write (`READ/`WRITE).
- s_addr  in  `WordAddrBus (30)  word address; bits [IDX_W-1:0] index the register.
- s_wr_data  in  `WordDataBus (32)  write data.
- s_rd_data  out  32  read data; valid only while s_rdy_ is low, otherwise 0.
- s_rdy_  out  1  ready, active low, one-cycle pulse.
- regs_o  out  NUM_REGS*32  flattened register contents; reg i at [32i+31:32i].

Behaviour:
- States: IDLE, WAIT, ACK. Reset (sync, priority over everything): state=IDLE, s_rdy_=`DISABLE_ (1), s_rd_data=0, all registers=0, wait counter=0, latches=0.
- IDLE: on an edge where s_cs_=0 and s_as_=0, latch s_addr index, s_rw and s_wr_data.
  - WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go directly to ACK.
- WAIT: counter decrements each cycle; when counter==0, go to ACK on the next edge. Time in WAIT is exactly WAIT_CYCLES cycles.
- Latency: s_rdy_ goes low WAIT_CYCLES+1 cycles after the accept edge (registered output), for exactly one cycle.
- ACK: s_rdy_=0 for this cycle only.
  - Read: s_rd_data = register[latched index], sampled on the edge entering ACK.
  - Write: s_rd_data=0; register[latched index] is updated on the edge entering ACK, so regs_o reflects it during the ACK cycle.
  - Next state is always IDLE.
- Requests while in WAIT or ACK are ignored, including changes on s_addr, s_wr_data and s_rw; only latched values are used. Back-to-back requests are therefore separated by at least one IDLE cycle.
- s_cs_ high with s_as_ low, or s_cs_ low with s_as_ high: no accept.
- Index width: only s_addr[IDX_W-1:0] is used; upper bits are ignored (aliasing is intentional; the decoder has already qualified the region).
- Reset mid-transaction: any pending write is discarded, no ready pulse is issued, and the block is in IDLE on the next cycle.
- s_rd_data is held at 0 outside ACK so the slave multiplexer may OR responses.

Decomposition:
- Shared header include/bus.h gains: `BusSlaveStateBus (2 bits), state encodings `BUS_SLAVE_IDLE=0, `BUS_SLAVE_WAIT=1, `BUS_SLAVE_ACK=2, and `BUS_SLAVE_WAIT_W (4).
- Reuse existing `ENABLE_/`DISABLE_, `READ/`WRITE, `WordAddrBus, `WordDataBus.
- No sub-module: the FSM, wait counter and register bank fit in one module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> s_rdy_=1, s_rd_data=0, regs_o=0; no accept with cs_=0 and as_=1.
- Write then read, WAIT_CYCLES=1: write 0xDEADBEEF to index 2 -> s_rdy_ low exactly 2 cycles after accept, regs_o[95:64]=0xDEADBEEF. Read index 2 -> ready at +2 with s_rd_data=0xDEADBEEF; s_rd_data=0 on the cycles before and after.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: read -> ready at +1 and +16 cycles respectively, pulse width 1.
- Busy ignore: accept a write of 0x11111111 to index 1, then during WAIT change to s_addr index 3 with data 0x22222222 while keeping strobes low -> only reg1=0x11111111, reg3 unchanged; one ready pulse total.
- Aliasing: write 0xA5A5A5A5 to s_addr=0x00000105 (NUM_REGS=4) -> reg1 updated.
- Reset mid-op: accept a write of 0x12345678 to index 0, assert reset during WAIT -> no ready pulse, reg0=0, state IDLE; a fresh read afterwards returns 0.
